seq_decoder: RTL and testbench

Registered, parametrised instruction decoder for the 9-puzzle datapath. It sits between the program ROM and the register file, ALU and data memory. It turns one 3-field instruction word per cycle into datapath control. It owns a configurable-depth return-address stack for CALL/RETURN, with occupancy reporting and optional overflow/underflow guarding. All outputs are flopped, so decode latency is exactly one clock.

---
 rtl/seq_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_seq_decoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_decoder.sv
// seq_decoder: registered one-cycle instruction decoder with a CALL/RETURN address stack.
// Optional build macro SEQ_DECODER_STACK_GUARD_EN blocks stack overflow/underflow and flags it on stack_err.

package seq_decoder_pkg;
    localparam logic [7:0] OPC_SET    = 8'd1;
    localparam logic [7:0] OPC_ADD    = 8'd2;
    localparam logic [7:0] OPC_SUB    = 8'd3;
    localparam logic [7:0] OPC_ADDREG = 8'd4;
    localparam logic [7:0] OPC_LOAD   = 8'd5;
    localparam logic [7:0] OPC_WRITE  = 8'd6;
    localparam logic [7:0] OPC_MOD    = 8'd7;
    localparam logic [7:0] OPC_DIV    = 8'd8;
    localparam logic [7:0] OPC_COPY   = 8'd9;
    localparam logic [7:0] OPC_INV    = 8'd10;
    localparam logic [7:0] OPC_CHECK  = 8'd11;
    localparam logic [7:0] OPC_CHECKR = 8'd12;
    localparam logic [7:0] OPC_LESS   = 8'd13;
    localparam logic [7:0] OPC_AUP    = 8'd14;
    localparam logic [7:0] OPC_ADW    = 8'd15;
    localparam logic [7:0] OPC_GOTO   = 8'd16;
    localparam logic [7:0] OPC_JNZ    = 8'd17;
    localparam logic [7:0] OPC_CALL   = 8'd18;
    localparam logic [7:0] OPC_RETURN = 8'd19;
endpackage

module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter int              DW    = 8,
    parameter int              AW    = 8,
    parameter int              DEPTH = 16,
    parameter logic [DW-1:0]   W_REG = DW'(8'hFE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      op_valid,
    input  logic [3*DW-1:0]           op,
    input  logic                      zf,
    input  logic [AW-1:0]             pc,
    output logic [AW-1:0]             pc_in,
    output logic                      pc_we,
    output logic [DW-1:0]             src0,
    output logic [DW-1:0]             src1,
    output logic [DW-1:0]             dst,
    output logic                      reg_we,
    output logic                      sel1,
    output logic                      sel2,
    output logic [DW-1:0]             data,
    output logic [DW-1:0]             alu_op,
    output logic                      mem_we,
    output logic [$clog2(DEPTH):0]    stack_level,
    output logic [AW-1:0]             stack_top,
    output logic                      stack_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DW-1:0] w_opc, w_a, w_b;
    logic [AW-1:0] w_pc_next, w_ret_addr;
    logic [AW-1:0] w_pc_in;
    logic [DW-1:0] w_src0, w_src1, w_dst, w_data, w_alu_op;
    logic          w_pc_we, w_reg_we, w_sel1, w_sel2, w_mem_we, w_push, w_pop;

    logic [AW-1:0] r_pc_in;
    logic [DW-1:0] r_src0, r_src1, r_dst, r_data, r_alu_op;
    logic          r_pc_we, r_reg_we, r_sel1, r_sel2, r_mem_we;

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [LW-1:0] r_level;
    logic [AW-1:0] r_top;

    assign w_opc      = op[3*DW-1:2*DW];
    assign w_a        = op[2*DW-1:DW];
    assign w_b        = op[DW-1:0];
    assign w_pc_next  = pc + AW'(1);
    // Underflowing RETURN without the guard deliberately reads the wrapped slot.
    assign w_ret_addr = r_mem[r_ptr - PW'(1)];

`ifdef SEQ_DECODER_STACK_GUARD_EN
    logic w_err_set, w_full, w_empty, r_stack_err;
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
`endif

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_pc_in  = '0;
        w_pc_we  = 1'b0;
        w_src0   = '1;
        w_src1   = '1;
        w_dst    = r_dst;
        w_reg_we = 1'b0;
        w_sel1   = 1'b0;
        w_sel2   = 1'b0;
        w_data   = '1;
        w_alu_op = '1;
        w_mem_we = 1'b0;
        w_push   = 1'b0;
        w_pop    = 1'b0;
`ifdef SEQ_DECODER_STACK_GUARD_EN
        w_err_set = 1'b0;
`endif
        if (op_valid) begin
            case (w_opc)
                DW'(OPC_SET): begin
                    w_alu_op = w_opc; w_data = w_b; w_dst = w_a; w_reg_we = 1'b1;
                end
                DW'(OPC_ADD), DW'(OPC_SUB): begin
                    w_alu_op = w_opc; w_data = w_b; w_dst = w_a; w_src1 = w_a; w_reg_we = 1'b1;
                end
                DW'(OPC_ADDREG): begin
                    w_alu_op = w_opc; w_src0 = w_a; w_src1 = w_b; w_dst = w_a;
                    w_sel1 = 1'b1; w_reg_we = 1'b1;
                end
                DW'(OPC_LOAD): begin
                    w_alu_op = w_opc; w_src1 = w_a; w_dst = w_b; w_sel2 = 1'b1; w_reg_we = 1'b1;
                end
                DW'(OPC_WRITE): begin
                    w_alu_op = w_opc; w_src0 = w_b; w_src1 = w_a; w_sel1 = 1'b1; w_mem_we = 1'b1;
                end
                DW'(OPC_MOD), DW'(OPC_DIV), DW'(OPC_COPY), DW'(OPC_INV): begin
                    w_alu_op = w_opc; w_src1 = w_a; w_dst = w_b; w_reg_we = 1'b1;
                end
                DW'(OPC_CHECK): begin
                    w_alu_op = w_opc; w_src1 = w_a; w_data = w_b;
                end
                DW'(OPC_CHECKR), DW'(OPC_LESS): begin
                    w_alu_op = w_opc; w_src0 = w_a; w_src1 = w_b; w_sel1 = 1'b1;
                end
                DW'(OPC_AUP), DW'(OPC_ADW): begin
                    w_alu_op = w_opc; w_src0 = w_a; w_src1 = w_b; w_sel1 = 1'b1;
                    w_dst = W_REG; w_reg_we = 1'b1;
                end
                DW'(OPC_GOTO): begin
                    w_pc_in = w_a[AW-1:0]; w_pc_we = 1'b1;
                end
                DW'(OPC_JNZ): begin
                    w_pc_in = w_a[AW-1:0]; w_pc_we = zf;
                end
                DW'(OPC_CALL): begin
`ifdef SEQ_DECODER_STACK_GUARD_EN
                    if (w_full) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_push = 1'b1; w_pc_in = w_a[AW-1:0]; w_pc_we = 1'b1;
                    end
`else
                    w_push = 1'b1; w_pc_in = w_a[AW-1:0]; w_pc_we = 1'b1;
`endif
                end
                DW'(OPC_RETURN): begin
`ifdef SEQ_DECODER_STACK_GUARD_EN
                    if (w_empty) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_pop = 1'b1; w_pc_in = w_ret_addr; w_pc_we = 1'b1;
                    end
`else
                    w_pop = 1'b1; w_pc_in = w_ret_addr; w_pc_we = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_in  <= '0;  r_pc_we  <= 1'b0;
            r_src0   <= '1;  r_src1   <= '1;  r_dst <= '0;
            r_reg_we <= 1'b0; r_sel1  <= 1'b0; r_sel2 <= 1'b0;
            r_data   <= '1;  r_alu_op <= '1;  r_mem_we <= 1'b0;
        end else begin
            r_pc_in  <= w_pc_in;  r_pc_we  <= w_pc_we;
            r_src0   <= w_src0;   r_src1   <= w_src1;  r_dst <= w_dst;
            r_reg_we <= w_reg_we; r_sel1   <= w_sel1;  r_sel2 <= w_sel2;
            r_data   <= w_data;   r_alu_op <= w_alu_op; r_mem_we <= w_mem_we;
        end
    end

    // NOTE: the stack array is cleared on reset so an early RETURN jumps to 0, not to stale data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_ptr   <= '0;
            r_level <= '0;
            r_top   <= '0;
        end else if (w_push) begin
            r_mem[r_ptr] <= w_pc_next;
            r_ptr        <= r_ptr + PW'(1);
            r_top        <= w_pc_next;
            if (r_level != LW'(DEPTH)) r_level <= r_level + LW'(1);
        end else if (w_pop) begin
            r_ptr <= r_ptr - PW'(1);
            r_top <= (r_level > LW'(1)) ? r_mem[r_ptr - PW'(2)] : '0;
            if (r_level != '0) r_level <= r_level - LW'(1);
        end
    end

`ifdef SEQ_DECODER_STACK_GUARD_EN
    always_ff @(posedge clk) begin
        if (!rst_n)         r_stack_err <= 1'b0;
        else if (w_err_set) r_stack_err <= 1'b1;
    end
    assign stack_err = r_stack_err;
`else
    assign stack_err = 1'b0;
`endif

    assign pc_in       = r_pc_in;
    assign pc_we       = r_pc_we;
    assign src0        = r_src0;
    assign src1        = r_src1;
    assign dst         = r_dst;
    assign reg_we      = r_reg_we;
    assign sel1        = r_sel1;
    assign sel2        = r_sel2;
    assign data        = r_data;
    assign alu_op      = r_alu_op;
    assign mem_we      = r_mem_we;
    assign stack_level = r_level;
    assign stack_top   = r_top;

endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: vector table, stack corner sequences, then random ops against a queue-based model.
// Expectations follow SEQ_DECODER_STACK_GUARD_EN when it is defined for the build.

module tb_seq_decoder;
    import seq_decoder_pkg::*;

    localparam int DW = 8, AW = 8, DEPTH = 16, LW = 5;
`ifdef SEQ_DECODER_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk, rst_n, op_valid, zf;
    logic [23:0]   op;
    logic [7:0]    pc, pc_in, src0, src1, dst, data, alu_op, stack_top;
    logic          pc_we, reg_we, sel1, sel2, mem_we, stack_err;
    logic [LW-1:0] stack_level;

    seq_decoder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .W_REG(8'hFE)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .zf(zf), .pc(pc),
        .pc_in(pc_in), .pc_we(pc_we), .src0(src0), .src1(src1), .dst(dst),
        .reg_we(reg_we), .sel1(sel1), .sel2(sel2), .data(data), .alu_op(alu_op),
        .mem_we(mem_we), .stack_level(stack_level), .stack_top(stack_top),
        .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc_in; logic pc_we; logic [7:0] src0, src1, dst; logic reg_we;
        logic sel1, sel2; logic [7:0] data, alu_op; logic mem_we;
        logic [LW-1:0] stack_level; logic [7:0] stack_top; logic stack_err;
    } out_t;

    typedef struct {
        logic v; logic [7:0] opc, a, b; logic zf; out_t exp;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[$];

    // Reference state: the return stack as a plain list of addresses, oldest first.
    logic [7:0] m_stack[$];
    logic       m_err;
    logic [7:0] m_dst;
    out_t       m_exp;
    logic       m_skip;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input out_t e, input logic skip_pc_in);
        if (!skip_pc_in) check({name, ".pc_in"}, 32'(pc_in), 32'(e.pc_in));
        check({name, ".pc_we"},       32'(pc_we),       32'(e.pc_we));
        check({name, ".src0"},        32'(src0),        32'(e.src0));
        check({name, ".src1"},        32'(src1),        32'(e.src1));
        check({name, ".dst"},         32'(dst),         32'(e.dst));
        check({name, ".reg_we"},      32'(reg_we),      32'(e.reg_we));
        check({name, ".sel1"},        32'(sel1),        32'(e.sel1));
        check({name, ".sel2"},        32'(sel2),        32'(e.sel2));
        check({name, ".data"},        32'(data),        32'(e.data));
        check({name, ".alu_op"},      32'(alu_op),      32'(e.alu_op));
        check({name, ".mem_we"},      32'(mem_we),      32'(e.mem_we));
        check({name, ".stack_level"}, 32'(stack_level), 32'(e.stack_level));
        check({name, ".stack_top"},   32'(stack_top),   32'(e.stack_top));
        check({name, ".stack_err"},   32'(stack_err),   32'(e.stack_err));
    endtask

    function automatic out_t dflt(input logic [7:0] d);
        out_t e;
        e.pc_in = 8'h00; e.pc_we = 1'b0; e.src0 = 8'hFF; e.src1 = 8'hFF; e.dst = d;
        e.reg_we = 1'b0; e.sel1 = 1'b0; e.sel2 = 1'b0; e.data = 8'hFF; e.alu_op = 8'hFF;
        e.mem_we = 1'b0; e.stack_level = '0; e.stack_top = 8'h00; e.stack_err = 1'b0;
        return e;
    endfunction

    task automatic add(input logic v, input logic [7:0] opc, a, b, input logic z, input out_t e);
        vec_t t;
        t.v = v; t.opc = opc; t.a = a; t.b = b; t.zf = z; t.exp = e;
        tbl.push_back(t);
    endtask

    // Predicts the outputs after one edge from the instruction's documented effect.
    task automatic model_step(input logic rst, v, input logic [7:0] opc, a, b,
                              input logic z, input logic [7:0] p);
        out_t e;
        e = dflt(m_dst);
        m_skip = 1'b0;
        if (!rst) begin
            m_stack.delete();
            m_err = 1'b0;
            e.dst = 8'h00;
        end else if (v) begin
            if (opc == OPC_SET) begin
                e.alu_op = opc; e.data = b; e.dst = a; e.reg_we = 1'b1;
            end else if (opc == OPC_ADD || opc == OPC_SUB) begin
                e.alu_op = opc; e.data = b; e.dst = a; e.src1 = a; e.reg_we = 1'b1;
            end else if (opc == OPC_ADDREG) begin
                e.alu_op = opc; e.src0 = a; e.src1 = b; e.dst = a; e.sel1 = 1'b1; e.reg_we = 1'b1;
            end else if (opc == OPC_LOAD) begin
                e.alu_op = opc; e.src1 = a; e.dst = b; e.sel2 = 1'b1; e.reg_we = 1'b1;
            end else if (opc == OPC_WRITE) begin
                e.alu_op = opc; e.src0 = b; e.src1 = a; e.sel1 = 1'b1; e.mem_we = 1'b1;
            end else if (opc inside {OPC_MOD, OPC_DIV, OPC_COPY, OPC_INV}) begin
                e.alu_op = opc; e.src1 = a; e.dst = b; e.reg_we = 1'b1;
            end else if (opc == OPC_CHECK) begin
                e.alu_op = opc; e.src1 = a; e.data = b;
            end else if (opc == OPC_CHECKR || opc == OPC_LESS) begin
                e.alu_op = opc; e.src0 = a; e.src1 = b; e.sel1 = 1'b1;
            end else if (opc == OPC_AUP || opc == OPC_ADW) begin
                e.alu_op = opc; e.src0 = a; e.src1 = b; e.sel1 = 1'b1; e.dst = 8'hFE; e.reg_we = 1'b1;
            end else if (opc == OPC_GOTO) begin
                e.pc_in = a; e.pc_we = 1'b1;
            end else if (opc == OPC_JNZ) begin
                e.pc_in = a; e.pc_we = z;
            end else if (opc == OPC_CALL) begin
                if (GUARD && m_stack.size() == DEPTH) begin
                    m_err = 1'b1;
                end else begin
                    m_stack.push_back(8'(p + 8'd1));
                    if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
                    e.pc_in = a; e.pc_we = 1'b1;
                end
            end else if (opc == OPC_RETURN) begin
                if (m_stack.size() == 0) begin
                    if (GUARD) m_err = 1'b1;
                    else begin e.pc_we = 1'b1; m_skip = 1'b1; end
                end else begin
                    e.pc_in = m_stack.pop_back(); e.pc_we = 1'b1;
                end
            end
        end
        m_dst = e.dst;
        e.stack_level = LW'(m_stack.size());
        e.stack_top   = (m_stack.size() > 0) ? m_stack[$] : 8'h00;
        e.stack_err   = m_err;
        m_exp = e;
    endtask

    task automatic step(input string name, input logic rst, v, input logic [7:0] opc, a, b,
                        input logic z, input logic [7:0] p);
        rst_n = rst; op_valid = v; op = {opc, a, b}; zf = z; pc = p;
        model_step(rst, v, opc, a, b, z, p);
        @(posedge clk);
        #1;
        check_out(name, m_exp, m_skip);
    endtask

    out_t       e;
    logic       r_r, r_v, r_z;
    logic [7:0] r_opc, r_a, r_b, r_p;
    int         sel;
    logic       call_bias;

    initial begin
        m_err = 1'b0; m_dst = 8'h00; m_skip = 1'b0;
        rst_n = 1'b0; op_valid = 1'b1; op = {OPC_CALL, 8'h12, 8'h34}; zf = 1'b0; pc = 8'h00;
        @(posedge clk);
        #1;
        check_out("reset", dflt(8'h00), 1'b0);

        // Single-cycle decode vectors, applied in order so dst carries between rows.
        e = dflt(8'h00); add(1'b0, OPC_SET, 8'h11, 8'h22, 1'b0, e);
        e = dflt(8'h03); e.alu_op = OPC_ADDREG; e.src0 = 8'h03; e.src1 = 8'h05; e.sel1 = 1'b1; e.reg_we = 1'b1;
        add(1'b1, OPC_ADDREG, 8'h03, 8'h05, 1'b0, e);
        e = dflt(8'h11); e.alu_op = OPC_SET; e.data = 8'h22; e.reg_we = 1'b1;
        add(1'b1, OPC_SET, 8'h11, 8'h22, 1'b0, e);
        e = dflt(8'h07); e.alu_op = OPC_ADD; e.data = 8'h09; e.src1 = 8'h07; e.reg_we = 1'b1;
        add(1'b1, OPC_ADD, 8'h07, 8'h09, 1'b0, e);
        e = dflt(8'h0A); e.alu_op = OPC_SUB; e.data = 8'h01; e.src1 = 8'h0A; e.reg_we = 1'b1;
        add(1'b1, OPC_SUB, 8'h0A, 8'h01, 1'b0, e);
        e = dflt(8'h04); e.alu_op = OPC_LOAD; e.src1 = 8'h30; e.sel2 = 1'b1; e.reg_we = 1'b1;
        add(1'b1, OPC_LOAD, 8'h30, 8'h04, 1'b0, e);
        e = dflt(8'h04); e.alu_op = OPC_WRITE; e.src0 = 8'h06; e.src1 = 8'h50; e.sel1 = 1'b1; e.mem_we = 1'b1;
        add(1'b1, OPC_WRITE, 8'h50, 8'h06, 1'b0, e);
        e = dflt(8'h13); e.alu_op = OPC_MOD; e.src1 = 8'h12; e.reg_we = 1'b1;
        add(1'b1, OPC_MOD, 8'h12, 8'h13, 1'b0, e);
        e = dflt(8'h09); e.alu_op = OPC_DIV; e.src1 = 8'h08; e.reg_we = 1'b1;
        add(1'b1, OPC_DIV, 8'h08, 8'h09, 1'b0, e);
        e = dflt(8'h2B); e.alu_op = OPC_COPY; e.src1 = 8'h2A; e.reg_we = 1'b1;
        add(1'b1, OPC_COPY, 8'h2A, 8'h2B, 1'b0, e);
        e = dflt(8'h22); e.alu_op = OPC_INV; e.src1 = 8'h21; e.reg_we = 1'b1;
        add(1'b1, OPC_INV, 8'h21, 8'h22, 1'b0, e);
        e = dflt(8'h22); e.alu_op = OPC_CHECK; e.src1 = 8'h40; e.data = 8'h41;
        add(1'b1, OPC_CHECK, 8'h40, 8'h41, 1'b0, e);
        e = dflt(8'h22); e.alu_op = OPC_CHECKR; e.src0 = 8'h0C; e.src1 = 8'h0D; e.sel1 = 1'b1;
        add(1'b1, OPC_CHECKR, 8'h0C, 8'h0D, 1'b0, e);
        e = dflt(8'h22); e.alu_op = OPC_LESS; e.src0 = 8'h01; e.src1 = 8'h02; e.sel1 = 1'b1;
        add(1'b1, OPC_LESS, 8'h01, 8'h02, 1'b0, e);
        e = dflt(8'hFE); e.alu_op = OPC_AUP; e.src0 = 8'h05; e.src1 = 8'h06; e.sel1 = 1'b1; e.reg_we = 1'b1;
        add(1'b1, OPC_AUP, 8'h05, 8'h06, 1'b0, e);
        e = dflt(8'h13); add(1'b1, OPC_SET, 8'h13, 8'h00, 1'b0, e);
        e.alu_op = OPC_SET; e.data = 8'h00; e.reg_we = 1'b1; tbl[$].exp = e;
        e = dflt(8'hFE); e.alu_op = OPC_ADW; e.src0 = 8'h07; e.src1 = 8'h08; e.sel1 = 1'b1; e.reg_we = 1'b1;
        add(1'b1, OPC_ADW, 8'h07, 8'h08, 1'b0, e);
        e = dflt(8'hFE); add(1'b1, 8'hC3, 8'h01, 8'h02, 1'b1, e);
        e = dflt(8'hFE); add(1'b1, 8'h00, 8'h01, 8'h02, 1'b1, e);
        e = dflt(8'hFE); e.pc_in = 8'h77; e.pc_we = 1'b1; add(1'b1, OPC_GOTO, 8'h77, 8'h00, 1'b0, e);
        e = dflt(8'hFE); e.pc_in = 8'h20; add(1'b1, OPC_JNZ, 8'h20, 8'h00, 1'b0, e);
        e = dflt(8'hFE); e.pc_in = 8'h20; e.pc_we = 1'b1; add(1'b1, OPC_JNZ, 8'h20, 8'h00, 1'b1, e);

        foreach (tbl[k]) begin
            rst_n = 1'b1; op_valid = tbl[k].v; op = {tbl[k].opc, tbl[k].a, tbl[k].b};
            zf = tbl[k].zf; pc = 8'h00;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", k), tbl[k].exp, 1'b0);
        end

        // CALL then RETURN back to back.
        step("rst_a", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        step("call", 1'b1, 1'b1, OPC_CALL, 8'h40, 8'h00, 1'b0, 8'h10);
        check("call.pc_in_c", 32'(pc_in), 32'h40);
        check("call.top_c", 32'(stack_top), 32'h11);
        check("call.level_c", 32'(stack_level), 32'd1);
        step("ret", 1'b1, 1'b1, OPC_RETURN, 8'h00, 8'h00, 1'b0, 8'h45);
        check("ret.pc_in_c", 32'(pc_in), 32'h11);
        check("ret.level_c", 32'(stack_level), 32'd0);

        // DEPTH+1 CALLs, then DEPTH+1 RETURNs.
        step("rst_b", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i <= DEPTH; i++)
            step($sformatf("fill%0d", i), 1'b1, 1'b1, OPC_CALL, 8'(i), 8'h00, 1'b0, 8'(8'h80 + i));
        check("fill.level_c", 32'(stack_level), 32'd16);
`ifdef SEQ_DECODER_STACK_GUARD_EN
        check("fill.pc_we_c", 32'(pc_we), 32'd0);
        check("fill.err_c", 32'(stack_err), 32'd1);
`else
        check("fill.pc_we_c", 32'(pc_we), 32'd1);
        check("fill.top_c", 32'(stack_top), 32'h91);
`endif
        for (int i = 0; i <= DEPTH; i++) begin
            step($sformatf("drain%0d", i), 1'b1, 1'b1, OPC_RETURN, 8'h00, 8'h00, 1'b0, 8'h00);
            if (i < DEPTH) begin
`ifdef SEQ_DECODER_STACK_GUARD_EN
                check($sformatf("drain%0d.lifo_c", i), 32'(pc_in), 32'(8'h90 - i));
`else
                check($sformatf("drain%0d.lifo_c", i), 32'(pc_in), 32'(8'h91 - i));
`endif
            end
        end
`ifdef SEQ_DECODER_STACK_GUARD_EN
        check("drain.last_pc_we_c", 32'(pc_we), 32'd0);
`endif
        check("drain.level_c", 32'(stack_level), 32'd0);

        // Reset in the middle of a program, with a CALL on the bus.
        step("rst_c", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
`ifdef SEQ_DECODER_STACK_GUARD_EN
        step("uflow", 1'b1, 1'b1, OPC_RETURN, 8'h00, 8'h00, 1'b0, 8'h00);
`endif
        for (int i = 0; i < 3; i++)
            step($sformatf("pre%0d", i), 1'b1, 1'b1, OPC_CALL, 8'h60, 8'h00, 1'b0, 8'(8'h30 + i));
        step("pre_set", 1'b1, 1'b1, OPC_SET, 8'h33, 8'h01, 1'b0, 8'h00);
        check("pre.level_c", 32'(stack_level), 32'd3);
        step("midrst", 1'b0, 1'b1, OPC_CALL, 8'h55, 8'h00, 1'b0, 8'h50);
        check("midrst.level_c", 32'(stack_level), 32'd0);
        check("midrst.err_c", 32'(stack_err), 32'd0);
        check("midrst.dst_c", 32'(dst), 32'd0);
        step("post_ret", 1'b1, 1'b1, OPC_RETURN, 8'h00, 8'h00, 1'b0, 8'h00);
`ifdef SEQ_DECODER_STACK_GUARD_EN
        check("post_ret.pc_we_c", 32'(pc_we), 32'd0);
`else
        check("post_ret.pc_in_c", 32'(pc_in), 32'd0);
`endif

        // Random program with alternating CALL-heavy and RETURN-heavy phases.
        step("rst_d", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            call_bias = ((i / 90) % 2) == 0;
            r_r = ($urandom_range(0, 299) != 0);
            r_v = ($urandom_range(0, 9) != 0);
            r_z = 1'($urandom_range(0, 1));
            r_a = 8'($urandom_range(0, 255));
            r_b = 8'($urandom_range(0, 255));
            r_p = 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 99);
            if (sel < 30)      r_opc = call_bias ? OPC_CALL : OPC_RETURN;
            else if (sel < 42) r_opc = call_bias ? OPC_RETURN : OPC_CALL;
            else if (sel < 92) r_opc = 8'($urandom_range(1, 19));
            else               r_opc = 8'($urandom_range(20, 255));
            step($sformatf("rnd%0d", i), r_r, r_v, r_opc, r_a, r_b, r_z, r_p);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
